// File: rtl/conv_pkg.sv
// Shared definitions for the convolution accelerator bus-side logic:
// initiator state encoding, accelerator base address and register offsets.
package conv_pkg;

  typedef enum logic [2:0] {
    MST_IDLE,
    MST_FETCH,
    MST_CMD,
    MST_RSP,
    MST_DONE
  } mst_state_e;

  localparam logic [31:0] CONV_BASE      = 32'h1004_2000;
  localparam logic [31:0] CONV_CTRL_OFFS = 32'h0000_0040;
  localparam logic [31:0] CONV_FILT_OFFS = 32'h0000_0100;

endpackage

// File: rtl/conv_icb_master.sv
// ICB initiator: issues a burst of single-beat transactions to consecutive
// word addresses of the conv accelerator, one outstanding at a time.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | write burst: waiting for the next write word
// CMD   | command held valid until accepted
// RSP   | waiting for the response of the outstanding command
// DONE  | one-cycle done pulse, back to IDLE
module conv_icb_master
  import conv_pkg::*;
#(
  parameter int                ADDR_W = 32,
  parameter int                DATA_W = 32,
  parameter int                LEN_W  = 10,
  parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(CONV_BASE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                start_read,
  input  logic [ADDR_W-1:0]   start_offs,
  input  logic [LEN_W-1:0]    start_len,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                icb_cmd_valid,
  input  logic                icb_cmd_ready,
  output logic                icb_cmd_read,
  output logic [ADDR_W-1:0]   icb_cmd_addr,
  output logic [DATA_W-1:0]   icb_cmd_wdata,
  output logic [DATA_W/8-1:0] icb_cmd_wmask,
  input  logic                icb_rsp_valid,
  output logic                icb_rsp_ready,
  input  logic [DATA_W-1:0]   icb_rsp_rdata,
  input  logic                icb_rsp_err
);

  mst_state_e        state, state_nx;
  logic              dir;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remain;
  logic [DATA_W-1:0] wdata;
  logic              start_ok, wr_fire, rsp_fire;
  logic              unused_offs;

  assign unused_offs = ^start_offs[1:0];

  assign start_ok = (state == MST_IDLE) && start;
  assign wr_fire  = (state == MST_FETCH) && wr_valid;
  assign rsp_fire = (state == MST_RSP) && icb_rsp_valid && icb_rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= MST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    wr_ready      = 1'b0;
    icb_rsp_ready = 1'b0;
    rd_valid      = 1'b0;
    case (state)
      MST_IDLE: begin
        if (start) begin
          if (start_len == '0) state_nx = MST_DONE;
          else if (start_read) state_nx = MST_CMD;
          else                 state_nx = MST_FETCH;
        end
      end
      MST_FETCH: begin
        wr_ready = 1'b1;
        if (wr_valid) state_nx = MST_CMD;
      end
      MST_CMD: begin
        if (icb_cmd_ready) state_nx = MST_RSP;
      end
      MST_RSP: begin
        icb_rsp_ready = dir ? rd_ready : 1'b1;
        rd_valid      = dir && icb_rsp_valid;
        if (rsp_fire) begin
          // an errored beat aborts the burst; the rest is never issued
          if (icb_rsp_err || remain == LEN_W'(1)) state_nx = MST_DONE;
          else if (dir)                           state_nx = MST_CMD;
          else                                    state_nx = MST_FETCH;
        end
      end
      MST_DONE: state_nx = MST_IDLE;
      default:  state_nx = MST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      icb_cmd_valid <= 1'b0;
      dir           <= 1'b0;
      addr          <= '0;
      remain        <= '0;
      wdata         <= '0;
    end else begin
      busy          <= (state_nx != MST_IDLE);
      done          <= (state_nx == MST_DONE);
      icb_cmd_valid <= (state_nx == MST_CMD);
      if (start_ok) begin
        addr   <= BASE + {start_offs[ADDR_W-1:2], 2'b00};
        remain <= start_len;
        dir    <= start_read;
        err    <= 1'b0;
      end
      if (wr_fire) wdata <= wr_data;
      if (rsp_fire) begin
        addr   <= addr + ADDR_W'(4);
        remain <= remain - LEN_W'(1);
        if (icb_rsp_err) err <= 1'b1;
      end
    end
  end

  assign icb_cmd_addr  = addr;
  assign icb_cmd_wdata = wdata;
  assign icb_cmd_read  = dir;
  assign icb_cmd_wmask = dir ? '0 : '1;
  assign rd_data       = icb_rsp_rdata;

endmodule

// File: tb/tb_conv_icb_master.sv
// Bench for conv_icb_master: random ICB slave and streams, a burst-level
// reference model checked every cycle, plus directed scenarios with literal results.
module tb_conv_icb_master;
  import conv_pkg::*;

  localparam logic [31:0] BASE_A = 32'h1004_2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start_read = 1'b0;
  logic [31:0] start_offs = '0;
  logic [9:0]  start_len = '0;
  logic        busy, done, err;
  logic        wr_valid = 1'b0, wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid, rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        icb_cmd_valid, icb_cmd_ready = 1'b0, icb_cmd_read;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid = 1'b0, icb_rsp_ready, icb_rsp_err = 1'b0;
  logic [31:0] icb_rsp_rdata = '0;

  always #5 clk = ~clk;

  conv_icb_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_read(start_read),
    .start_offs(start_offs), .start_len(start_len), .busy(busy), .done(done), .err(err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err)
  );

  int n_checks = 0, n_errors = 0;

  // slave / stream behaviour knobs (percent probabilities)
  int p_cmd = 100, p_rsp = 100, p_wr = 100, p_rd = 100, p_err = 0;
  int err_at = -1, stall_arm = 0, stall_left = 0, cmd_cycles = 0;
  bit rd_toggle = 0, rd_seq = 0, wr_fixed = 0;
  logic [31:0] wr_fixed_val = '0, rd_seq_base = '0;

  // burst-level reference model
  bit chk_en = 0, exp_busy = 0, exp_err = 0, exp_end = 0;
  bit pend = 0, pend_err = 0, rsp_up = 0, cur_read = 0, done_s = 0;
  logic [31:0] pend_data = '0, cur_base = '0;
  int cur_len = 0, ncmd = 0, nrsp = 0;
  logic [31:0] wq[$], cmd_log[$], rd_got[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic knobs(input int c, input int r, input int w, input int d, input int e);
    p_cmd = c; p_rsp = r; p_wr = w; p_rd = d; p_err = e;
  endtask

  // one clock cycle: entered just after a falling edge, leaves after the next one
  task automatic step();
    bit cmd_hs, rsp_hs, wr_hs, rd_hs, st_acc, end_now;
    if (stall_arm != 0 && icb_cmd_valid) begin
      stall_left = 5;
      stall_arm  = 0;
    end
    icb_cmd_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < p_cmd);
    if (pend) begin
      icb_rsp_valid = rsp_up || ($urandom_range(99) < p_rsp);
      icb_rsp_rdata = pend_data;
      icb_rsp_err   = pend_err;
    end else begin
      icb_rsp_valid = 1'b0;
      icb_rsp_rdata = $urandom;
      icb_rsp_err   = 1'($urandom_range(1));
    end
    wr_valid = ($urandom_range(99) < p_wr);
    wr_data  = wr_fixed ? wr_fixed_val : $urandom;
    rd_ready = rd_toggle ? ~rd_ready : ($urandom_range(99) < p_rd);
    #1;
    done_s = done;
    if (chk_en) begin
      chk("busy", busy, exp_busy);
      chk("done", done, exp_end);
      chk("err", err, exp_err);
      chk("rd_valid", rd_valid, pend && cur_read && icb_rsp_valid);
      if (rd_valid) chk("rd_data", rd_data, icb_rsp_rdata);
      if (pend) chk("rsp_ready", icb_rsp_ready, cur_read ? rd_ready : 1'b1);
      else      chk("rsp_ready_idle", icb_rsp_ready, 1'b0);
      if (!exp_busy || pend) chk("cmd_valid_quiet", icb_cmd_valid, 1'b0);
      if (wr_ready)
        chk("wr_ready_when", {exp_busy, exp_end, cur_read, pend, icb_cmd_valid}, 5'b10000);
      if (icb_cmd_valid && exp_busy && !pend) begin
        chk("cmd_addr", icb_cmd_addr, cur_base + 32'(ncmd) * 32'd4);
        chk("cmd_read", icb_cmd_read, cur_read);
        chk("cmd_wmask", icb_cmd_wmask, cur_read ? 4'h0 : 4'hF);
        if (!cur_read) chk("cmd_wdata", icb_cmd_wdata, (wq.size() > 0) ? wq[0] : ~icb_cmd_wdata);
        chk("cmd_count", ncmd < cur_len, 1'b1);
      end
    end
    cmd_hs = icb_cmd_valid && icb_cmd_ready;
    rsp_hs = icb_rsp_valid && icb_rsp_ready;
    wr_hs  = wr_valid && wr_ready;
    rd_hs  = rd_valid && rd_ready;
    st_acc = start && !exp_busy;
    if (icb_cmd_valid) cmd_cycles++;
    @(posedge clk);
    if (stall_left > 0) stall_left--;
    if (!rst_n) begin
      exp_busy = 0; exp_err = 0; exp_end = 0; pend = 0; rsp_up = 0;
      wq.delete();
    end else begin
      end_now = 0;
      if (wr_hs) wq.push_back(wr_data);
      if (rsp_hs && pend) begin
        pend = 0; rsp_up = 0; nrsp++;
        if (rd_hs) rd_got.push_back(icb_rsp_rdata);
        if (pend_err) exp_err = 1;
        if (pend_err || nrsp == cur_len) end_now = 1;
      end else if (pend && icb_rsp_valid) begin
        rsp_up = 1;
      end
      if (cmd_hs) begin
        cmd_log.push_back(icb_cmd_addr);
        if (!cur_read && wq.size() > 0) void'(wq.pop_front());
        pend      = 1;
        pend_data = rd_seq ? rd_seq_base + 32'(ncmd) : $urandom;
        pend_err  = (ncmd == err_at) || ($urandom_range(99) < p_err);
        ncmd++;
      end
      if (st_acc) begin
        exp_err  = 0;
        cur_read = start_read;
        cur_base = BASE_A + (start_offs & ~32'h3);
        cur_len  = int'(start_len);
        ncmd = 0; nrsp = 0;
        wq.delete();
        if (start_len == 10'd0) end_now = 1;
      end
      if (st_acc)       exp_busy = 1;
      else if (exp_end) exp_busy = 0;
      exp_end = end_now;
    end
    @(negedge clk);
  endtask

  // issue one start, then run until done is seen; cyc = cycles from start to done
  task automatic run_burst(input bit rd, input logic [31:0] offs, input int len,
                           input int stray, output int cyc);
    start = 1'b1; start_read = rd; start_offs = offs; start_len = 10'(len);
    step();
    start  = 1'b0;
    cyc    = 0;
    done_s = 0;
    while (!done_s) begin
      if (cyc >= 400) begin
        n_checks++; n_errors++;
        $display("FAIL burst_timeout: got no done after %0d cycles expected done", cyc);
        break;
      end
      if ($urandom_range(99) < stray) begin
        start = 1'b1; start_read = 1'($urandom);
        start_offs = $urandom; start_len = 10'($urandom);
      end
      step();
      start = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got simulation still running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic [31:0] exp_a[4];

    rst_n = 1'b0;
    repeat (3) step();
    rst_n  = 1'b1;
    chk_en = 1;

    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cmd_valid", icb_cmd_valid, 1'b0);
    chk("rst_rsp_ready", icb_rsp_ready, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_addr", icb_cmd_addr, 32'h0);
    chk("rst_wdata", icb_cmd_wdata, 32'h0);

    // single-word write, zero-wait slave
    knobs(100, 100, 100, 100, 0);
    wr_fixed = 1; wr_fixed_val = 32'h1;
    cmd_log.delete();
    run_burst(1'b0, CONV_CTRL_OFFS, 1, 0, cyc);
    wr_fixed = 0;
    chk("wr1_ncmd", cmd_log.size(), 1);
    if (cmd_log.size() > 0) chk("wr1_addr", cmd_log[0], 32'h1004_2040);
    chk("wr1_wdata", icb_cmd_wdata, 32'h1);
    chk("wr1_latency", cyc, 4);
    chk("wr1_err", err, 1'b0);

    // read burst with consumer backpressure
    rd_seq = 1; rd_seq_base = 32'hA0; rd_toggle = 1;
    rd_got.delete(); cmd_log.delete();
    run_burst(1'b1, CONV_FILT_OFFS, 4, 0, cyc);
    rd_seq = 0; rd_toggle = 0;
    exp_a = '{32'h1004_2100, 32'h1004_2104, 32'h1004_2108, 32'h1004_210C};
    chk("rd4_nbeats", rd_got.size(), 4);
    chk("rd4_ncmd", cmd_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_got.size())  chk("rd4_data", rd_got[i], 32'hA0 + 32'(i));
      if (i < cmd_log.size()) chk("rd4_addr", cmd_log[i], exp_a[i]);
    end

    // zero-wait read latency: 2 cycles per word
    cmd_log.delete();
    run_burst(1'b1, 32'h0, 4, 0, cyc);
    chk("rd4_latency", cyc, 9);

    // command stall of 5 cycles
    cmd_log.delete(); cmd_cycles = 0; stall_arm = 1;
    run_burst(1'b0, 32'h0000_0013, 1, 0, cyc);
    chk("stall_valid_cycles", cmd_cycles, 6);
    chk("stall_ncmd", cmd_log.size(), 1);
    if (cmd_log.size() > 0) chk("stall_addr", cmd_log[0], 32'h1004_2010);
    chk("stall_latency", cyc, 9);

    // error on the 2nd response aborts a 3-word read
    cmd_log.delete(); err_at = 1;
    run_burst(1'b1, 32'h0, 3, 0, cyc);
    err_at = -1;
    chk("abort_ncmd", cmd_log.size(), 2);
    chk("abort_err", err, 1'b1);
    run_burst(1'b1, 32'h0, 1, 0, cyc);
    chk("abort_err_cleared", err, 1'b0);

    // zero length, then starts pulsed throughout a busy burst
    cmd_log.delete();
    run_burst(1'b0, 32'h0, 0, 0, cyc);
    chk("zero_latency", cyc, 1);
    chk("zero_ncmd", cmd_log.size(), 0);
    run_burst(1'b0, CONV_CTRL_OFFS, 2, 100, cyc);
    chk("ignored_ncmd", cmd_log.size(), 2);
    if (cmd_log.size() > 1) chk("ignored_addr", cmd_log[1], 32'h1004_2044);

    // reset while word 2 of 4 is in its command phase
    start = 1'b1; start_read = 1'b1; start_offs = 32'h0; start_len = 10'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ncmd == 1 && icb_cmd_valid) break;
      step();
    end
    chk("rst_mid_in_cmd", {ncmd == 1, icb_cmd_valid}, 2'b11);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_mid_cmd_valid", icb_cmd_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    cmd_log.delete();
    run_burst(1'b0, 32'h0000_0008, 2, 0, cyc);
    chk("after_rst_ncmd", cmd_log.size(), 2);
    if (cmd_log.size() > 0) chk("after_rst_addr", cmd_log[0], 32'h1004_2008);

    // randomized bursts against the model
    for (int b = 0; b < 40; b++) begin
      knobs($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 30),
            $urandom_range(100, 30), 8);
      run_burst(1'($urandom), $urandom, $urandom_range(6, 0), 10, cyc);
      if ($urandom_range(3) == 0) step();
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
